// File: rtl/tone_osc.sv
// tone_osc: divider-driven square/sawtooth/triangle oscillator with wrap-aligned retuning
module tone_osc #(
  parameter int DIV_W    = 19,
  parameter int SAMPLE_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [DIV_W-1:0]    divider,
  input  logic [1:0]          wave_sel,
  output logic [SAMPLE_W-1:0] sample,
  output logic                period_tick
);
  localparam int STEP_W = DIV_W - SAMPLE_W;
  localparam logic [SAMPLE_W-1:0] MID = {1'b1, {(SAMPLE_W-1){1'b0}}};
  typedef enum logic {IDLE, RUN} state_t;
  state_t              state_q, state_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [STEP_W-1:0]   step_q, sub_q, sub_d;
  logic [SAMPLE_W-1:0] ramp_q, ramp_d, sample_q, sample_d, shape;
  logic                tick_q, tick_d, stepping, wrap, new_silent;
  assign step_q = STEP_W'(div_q >> SAMPLE_W);
  assign new_silent = (divider >> SAMPLE_W) == '0;
  always_comb begin
    stepping = sub_q == step_q - 1'b1;
    wrap = stepping && ramp_q == '1;
    state_d = state_q;
    div_d = div_q;
    sub_d = '0;
    ramp_d = '0;
    tick_d = 1'b0;
    if (state_q == IDLE) begin
      div_d = divider;
      state_d = (en && !new_silent) ? RUN : IDLE;
    end else if (!en) begin
      state_d = IDLE;
    end else begin
      sub_d = stepping ? '0 : sub_q + 1'b1;
      ramp_d = ramp_q + SAMPLE_W'(stepping);
      tick_d = wrap;
      // retune only at the period boundary so the waveform never glitches
      if (wrap) begin
        div_d = divider;
        state_d = new_silent ? IDLE : RUN;
      end
    end
    shape = wave_sel == 2'b00 ? (ramp_d[SAMPLE_W-1] ? '0 : '1) :
            wave_sel == 2'b01 ? ramp_d :
            wave_sel == 2'b10 ? (ramp_d[SAMPLE_W-1] ? {~ramp_d[SAMPLE_W-2:0], 1'b0}
                                                    : {ramp_d[SAMPLE_W-2:0], 1'b0}) :
            MID;
    sample_d = state_d == RUN ? shape : MID;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      div_q    <= '0;
      sub_q    <= '0;
      ramp_q   <= '0;
      sample_q <= MID;
      tick_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      sub_q    <= sub_d;
      ramp_q   <= ramp_d;
      sample_q <= sample_d;
      tick_q   <= tick_d;
    end
  end
  assign sample = sample_q;
  assign period_tick = tick_q;
endmodule
